// File: rtl/axis_cmd_gen_s2mm_ring.sv
// axis_cmd_gen_s2mm_ring: S2MM command generator with burst splitting, in-flight tracking and ring capture
module axis_cmd_gen_s2mm_ring #(
    parameter int ADDR_WIDTH      = 32,
    parameter int BTT_WIDTH       = 23,
    parameter int MAX_BURST_LEN   = 4096,
    parameter int MAX_OUTSTANDING = 4,
    localparam int CMD_W          = ADDR_WIDTH + 40
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic [CMD_W-1:0]      m_axis_cmd_tdata,
    output logic                  m_axis_cmd_tvalid,
    input  logic                  m_axis_cmd_tready,
    input  logic [7:0]            s_axis_sts_tdata,
    input  logic                  s_axis_sts_tvalid,
    output logic                  s_axis_sts_tready,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  mode_continuous,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [31:0]           cap_size,
    output logic                  busy,
    output logic                  cap_done,
    output logic                  err,
    output logic [4:0]            err_code,
    output logic [15:0]           wrap_cnt,
    output logic [31:0]           commit_ptr
);
    localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int DEPTH = 1 << PW;
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [31:0] MAX_B = 32'(MAX_BURST_LEN);
    localparam logic [OW-1:0] MAX_O = OW'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d, addr_q, addr_d;
    logic [31:0]           size_q, size_d, rem_q, rem_d;
    logic                  cont_q, cont_d;
    logic [3:0]            tag_q, tag_d, exp_tag_q, exp_tag_d;
    logic [OW-1:0]         out_q, out_d;
    logic [PW-1:0]         wr_q, wr_d, rd_q, rd_d;
    logic                  cmd_valid_q, cmd_valid_d;
    logic [CMD_W-1:0]      cmd_data_q, cmd_data_d;
    logic                  sts_ready_q;
    logic                  cap_done_q, cap_done_d, err_q, err_d;
    logic [4:0]            err_code_q, err_code_d;
    logic [15:0]           wrap_q, wrap_d;
    logic [31:0]           commit_q, commit_d;
    logic [32:0]           fifo_mem [DEPTH];

    logic        cmd_hs, sts_hs, last, sof, fifo_empty, mismatch, sts_bad;
    logic [31:0] chunk;
    logic [32:0] head;
    logic [CMD_W-1:0] cmd_word;

    assign cmd_hs     = cmd_valid_q && m_axis_cmd_tready;
    assign sts_hs     = s_axis_sts_tvalid && sts_ready_q;
    assign chunk      = (rem_q < MAX_B) ? rem_q : MAX_B;
    assign last       = (rem_q <= MAX_B);
    assign sof        = (rem_q == size_q);
    assign fifo_empty = (out_q == '0);
    assign head       = fifo_mem[rd_q];
    assign mismatch   = fifo_empty || (s_axis_sts_tdata[3:0] != exp_tag_q);
    assign sts_bad    = sts_hs && (mismatch || !s_axis_sts_tdata[7]);

    // Assemble the command word for the chunk at the current address
    always_comb begin
        cmd_word = '0;
        cmd_word[BTT_WIDTH-1:0] = chunk[BTT_WIDTH-1:0];
        cmd_word[23] = sof;
        cmd_word[30] = last;
        cmd_word[31] = 1'b1;
        cmd_word[ADDR_WIDTH+31:32] = addr_q;
        cmd_word[ADDR_WIDTH+35:ADDR_WIDTH+32] = tag_q;
    end

    // Next-state: command issue, status retirement, error capture and run control
    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        addr_d      = addr_q;
        size_d      = size_q;
        rem_d       = rem_q;
        cont_d      = cont_q;
        tag_d       = tag_q;
        exp_tag_d   = exp_tag_q;
        out_d       = out_q + OW'(cmd_hs) - OW'(sts_hs && !fifo_empty);
        wr_d        = wr_q + PW'(cmd_hs);
        rd_d        = rd_q + PW'(sts_hs && !fifo_empty);
        cmd_valid_d = cmd_valid_q;
        cmd_data_d  = cmd_data_q;
        cap_done_d  = cap_done_q;
        err_d       = err_q;
        err_code_d  = err_code_q;
        wrap_d      = wrap_q;
        commit_d    = commit_q;
        if (cmd_hs) begin
            cmd_valid_d = 1'b0;
            tag_d = tag_q + 4'd1;
            addr_d = addr_q + ADDR_WIDTH'(chunk);
            rem_d = rem_q - chunk;
            if (last && cont_q) begin
                addr_d = base_q;
                rem_d = size_q;
            end
            if (last && !cont_q) state_d = DRAIN;
        end
        if (sts_hs) begin
            exp_tag_d = exp_tag_q + 4'd1;
            if (!fifo_empty) begin
                commit_d = head[32] ? '0 : commit_q + head[31:0];
                wrap_d = head[32] ? wrap_q + 16'd1 : wrap_q;
            end
            if (sts_bad && !err_q) begin
                err_d = 1'b1;
                err_code_d = {mismatch, ~s_axis_sts_tdata[7], s_axis_sts_tdata[6:4]};
            end
            if (sts_bad && state_q != IDLE) state_d = DRAIN;
        end
        if (state_q == ISSUE && stop) state_d = DRAIN;
        if (state_q == ISSUE && !stop && !sts_bad && !cmd_valid_q && rem_q != '0 && out_q < MAX_O) begin
            cmd_valid_d = 1'b1;
            cmd_data_d = cmd_word;
        end
        if (state_q == DRAIN && fifo_empty && !cmd_valid_q) begin
            state_d = IDLE;
            cap_done_d = !err_q && !sts_bad;
        end
        if (state_q == IDLE && start && cap_size != '0) begin
            state_d    = ISSUE;
            base_d     = base_addr;
            addr_d     = base_addr;
            size_d     = cap_size;
            rem_d      = cap_size;
            cont_d     = mode_continuous;
            tag_d      = '0;
            exp_tag_d  = '0;
            cap_done_d = 1'b0;
            err_d      = 1'b0;
            err_code_d = '0;
            wrap_d     = '0;
            commit_d   = '0;
        end
    end

    // State and control registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            base_q      <= '0;
            addr_q      <= '0;
            size_q      <= '0;
            rem_q       <= '0;
            cont_q      <= 1'b0;
            tag_q       <= '0;
            exp_tag_q   <= '0;
            out_q       <= '0;
            wr_q        <= '0;
            rd_q        <= '0;
            cmd_valid_q <= 1'b0;
            cmd_data_q  <= '0;
            sts_ready_q <= 1'b0;
            cap_done_q  <= 1'b0;
            err_q       <= 1'b0;
            err_code_q  <= '0;
            wrap_q      <= '0;
            commit_q    <= '0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            addr_q      <= addr_d;
            size_q      <= size_d;
            rem_q       <= rem_d;
            cont_q      <= cont_d;
            tag_q       <= tag_d;
            exp_tag_q   <= exp_tag_d;
            out_q       <= out_d;
            wr_q        <= wr_d;
            rd_q        <= rd_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_data_q  <= cmd_data_d;
            sts_ready_q <= 1'b1;
            cap_done_q  <= cap_done_d;
            err_q       <= err_d;
            err_code_q  <= err_code_d;
            wrap_q      <= wrap_d;
            commit_q    <= commit_d;
        end
    end

    // In-flight FIFO holds {eof, chunk} of each accepted command until its status returns
    always_ff @(posedge clk) begin
        if (cmd_hs) fifo_mem[wr_q] <= {last, chunk};
    end

    assign m_axis_cmd_tdata  = cmd_data_q;
    assign m_axis_cmd_tvalid = cmd_valid_q;
    assign s_axis_sts_tready = sts_ready_q;
    assign busy              = (state_q != IDLE);
    assign cap_done          = cap_done_q;
    assign err               = err_q;
    assign err_code          = err_code_q;
    assign wrap_cnt          = wrap_q;
    assign commit_ptr        = commit_q;
endmodule

// File: tb/tb_axis_cmd_gen_s2mm_ring.sv
// tb_axis_cmd_gen_s2mm_ring: randomized directed bench with a transaction-level reference model
module tb_axis_cmd_gen_s2mm_ring;
    localparam int AW = 32;
    localparam int BW = 23;
    localparam int MAXB = 4096;
    localparam int MAXO = 4;
    localparam int CW = AW + 40;

    logic          clk = 1'b0;
    logic          reset;
    logic [CW-1:0] m_axis_cmd_tdata;
    logic          m_axis_cmd_tvalid;
    logic          m_axis_cmd_tready;
    logic [7:0]    s_axis_sts_tdata;
    logic          s_axis_sts_tvalid;
    logic          s_axis_sts_tready;
    logic          start, stop, mode_continuous;
    logic [AW-1:0] base_addr;
    logic [31:0]   cap_size;
    logic          busy, cap_done, err;
    logic [4:0]    err_code;
    logic [15:0]   wrap_cnt;
    logic [31:0]   commit_ptr;

    axis_cmd_gen_s2mm_ring #(
        .ADDR_WIDTH(AW), .BTT_WIDTH(BW), .MAX_BURST_LEN(MAXB), .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk(clk), .reset(reset),
        .m_axis_cmd_tdata(m_axis_cmd_tdata), .m_axis_cmd_tvalid(m_axis_cmd_tvalid),
        .m_axis_cmd_tready(m_axis_cmd_tready),
        .s_axis_sts_tdata(s_axis_sts_tdata), .s_axis_sts_tvalid(s_axis_sts_tvalid),
        .s_axis_sts_tready(s_axis_sts_tready),
        .start(start), .stop(stop), .mode_continuous(mode_continuous),
        .base_addr(base_addr), .cap_size(cap_size),
        .busy(busy), .cap_done(cap_done), .err(err), .err_code(err_code),
        .wrap_cnt(wrap_cnt), .commit_ptr(commit_ptr)
    );

    always #5 clk = ~clk;

    typedef struct packed {logic eof; logic [31:0] chunk;} fl_t;

    int checks = 0, failures = 0;
    fl_t fly[$];
    logic [3:0] pend[$];
    logic [31:0] m_addr, m_rem, m_base, m_size, m_commit;
    logic [15:0] m_wrap;
    logic [3:0] m_tag, m_exp;
    logic [4:0] m_code;
    logic m_cont, m_first, m_err;
    int halted = 1, allowed = 0, ncmd = 0, nsent = 0;
    int rdy_mode = 1, auto_sts = 0, budget = 0, err_kind = 0, err_idx = -1;
    logic prev_wait = 1'b0, prev_hs = 1'b0;
    logic [CW-1:0] prev_d = '0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [CW-1:0] build(input logic [31:0] a, input logic [31:0] btt,
                                            input logic sof, input logic eof, input logic [3:0] tag);
        logic [CW-1:0] w;
        w = '0;
        w[BW-1:0] = btt[BW-1:0];
        w[23] = sof;
        w[30] = eof;
        w[31] = 1'b1;
        w[AW+31:32] = a;
        w[AW+35:AW+32] = tag;
        return w;
    endfunction

    task automatic set_ready(input int mode);
        rdy_mode = mode;
        if (mode != 2) m_axis_cmd_tready = (mode == 1);
    endtask

    task automatic step();
        logic c_v, c_r, s_v, s_r, st, rs, mism, bad, eo;
        logic [CW-1:0] c_d;
        logic [7:0] s_d, w;
        logic [31:0] ch;
        logic [3:0] t;
        fl_t f;
        @(negedge clk);
        c_v = m_axis_cmd_tvalid; c_r = m_axis_cmd_tready; c_d = m_axis_cmd_tdata;
        s_v = s_axis_sts_tvalid; s_r = s_axis_sts_tready; s_d = s_axis_sts_tdata;
        st = stop; rs = reset;
        if (prev_wait) begin
            chk("cmd_hold_valid", c_v, 1);
            chk("cmd_hold_data", c_d, prev_d);
        end
        if (prev_hs) chk("cmd_gap", c_v, 0);
        @(posedge clk);
        #1;
        prev_wait = !rs && c_v && !c_r;
        prev_hs = !rs && c_v && c_r;
        prev_d = c_d;
        if (!rs) begin
            chk("sts_ready", s_axis_sts_tready, 1);
            if (c_v && c_r) begin
                ch = (m_rem < MAXB) ? m_rem : MAXB;
                eo = (m_rem <= MAXB);
                chk("cmd_outstanding", fly.size() < MAXO, 1);
                if (halted != 0) begin
                    chk("cmd_after_halt", allowed > 0, 1);
                    if (allowed > 0) allowed--;
                end
                chk("cmd_word", c_d, build(m_addr, ch, m_first, eo, m_tag));
                fly.push_back({eo, ch});
                pend.push_back(m_tag);
                m_addr += ch;
                m_rem -= ch;
                m_tag++;
                m_first = 1'b0;
                ncmd++;
                if (eo && m_cont) begin
                    m_addr = m_base;
                    m_rem = m_size;
                    m_first = 1'b1;
                end else if (eo) begin
                    halted = 1;
                    allowed = 0;
                end
            end
            if (st && halted == 0) begin
                halted = 1;
                allowed = (c_v && !c_r) ? 1 : 0;
            end
            if (s_v && s_r) begin
                mism = (fly.size() == 0) || (s_d[3:0] != m_exp);
                bad = mism || !s_d[7];
                if (bad && !m_err) begin
                    m_err = 1'b1;
                    m_code = {mism, ~s_d[7], s_d[6:4]};
                end
                if (bad && halted == 0) begin
                    halted = 1;
                    allowed = (c_v && !c_r) ? 1 : 0;
                end
                m_exp++;
                if (fly.size() > 0) begin
                    f = fly.pop_front();
                    if (f.eof) begin
                        m_wrap++;
                        m_commit = 0;
                    end else m_commit += f.chunk;
                end
                chk("commit_ptr", commit_ptr, m_commit);
                chk("wrap_cnt", wrap_cnt, m_wrap);
                chk("err", err, m_err);
                chk("err_code", err_code, m_code);
            end
        end
        if (rdy_mode == 2) m_axis_cmd_tready = 1'($urandom_range(0, 1));
        else m_axis_cmd_tready = (rdy_mode == 1);
        s_axis_sts_tvalid = 1'b0;
        s_axis_sts_tdata = '0;
        if (!reset && pend.size() > 0 && (auto_sts != 0 ? ($urandom_range(0, 2) != 0) : (budget > 0))) begin
            t = pend.pop_front();
            if (auto_sts == 0) budget--;
            w = {4'b1000, t};
            if (err_kind == 1 && nsent == err_idx) w = {4'b0100, t};
            if (err_kind == 2 && nsent == err_idx) w = 8'h83;
            nsent++;
            s_axis_sts_tvalid = 1'b1;
            s_axis_sts_tdata = w;
        end
    endtask

    task automatic start_run(input logic [31:0] b, input logic [31:0] s, input logic c);
        base_addr = b;
        cap_size = s;
        mode_continuous = c;
        start = 1'b1;
        step();
        start = 1'b0;
        m_base = b; m_size = s; m_cont = c; m_addr = b; m_rem = s; m_first = 1'b1;
        m_tag = 0; m_exp = 0; m_commit = 0; m_wrap = 0; m_err = 1'b0; m_code = 0;
        halted = 0; allowed = 0; ncmd = 0; nsent = 0;
    endtask

    task automatic wait_idle(input string tag, input int max);
        int n;
        n = 0;
        while (busy && n < max) begin
            step();
            n++;
        end
        chk(tag, busy, 0);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_tvalid"}, m_axis_cmd_tvalid, 0);
        chk({tag, "_tdata"}, m_axis_cmd_tdata, 0);
        chk({tag, "_sts_ready"}, s_axis_sts_tready, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_cap_done"}, cap_done, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_err_code"}, err_code, 0);
        chk({tag, "_wrap"}, wrap_cnt, 0);
        chk({tag, "_commit"}, commit_ptr, 0);
    endtask

    initial begin
        int n, n0;
        logic [CW-1:0] held;
        reset = 1'b1; start = 1'b0; stop = 1'b0; mode_continuous = 1'b0;
        base_addr = '0; cap_size = '0; m_axis_cmd_tready = 1'b0;
        s_axis_sts_tvalid = 1'b0; s_axis_sts_tdata = '0;
        m_cont = 0; m_first = 0; m_err = 0; m_code = 0; m_wrap = 0; m_commit = 0;
        m_addr = 0; m_rem = 0; m_base = 0; m_size = 0; m_tag = 0; m_exp = 0;
        repeat (3) step();
        check_reset("reset");
        reset = 1'b0;
        step();
        step();

        base_addr = 32'h0000_1000; cap_size = 0; start = 1'b1;
        step();
        start = 1'b0;
        repeat (3) step();
        chk("zero_size_busy", busy, 0);
        chk("zero_size_tvalid", m_axis_cmd_tvalid, 0);

        set_ready(1); auto_sts = 1;
        start_run(32'h1000_0000, 10000, 1'b0);
        chk("oneshot_busy_n1", busy, 1);
        chk("oneshot_tvalid_n1", m_axis_cmd_tvalid, 0);
        step();
        chk("oneshot_tvalid_n2", m_axis_cmd_tvalid, 1);
        wait_idle("oneshot_timeout", 500);
        chk("oneshot_ncmd", ncmd, 3);
        chk("oneshot_cap_done", cap_done, 1);
        chk("oneshot_wrap", wrap_cnt, 1);
        chk("oneshot_err", err, 0);

        auto_sts = 0; budget = 0;
        start_run(32'h2000_0000, 32768, 1'b0);
        repeat (40) step();
        chk("ost_ncmd4", ncmd, 4);
        chk("ost_tvalid4", m_axis_cmd_tvalid, 0);
        budget = 1;
        repeat (20) step();
        chk("ost_ncmd5", ncmd, 5);
        chk("ost_tvalid5", m_axis_cmd_tvalid, 0);
        auto_sts = 1; set_ready(2);
        wait_idle("ost_timeout", 1000);
        chk("ost_ncmd8", ncmd, 8);
        chk("ost_cap_done", cap_done, 1);

        start_run(32'h3000_0000, 8192, 1'b1);
        n = 0;
        while (m_wrap < 3 && n < 4000) begin
            step();
            n++;
        end
        chk("ring_wrap3", wrap_cnt, 3);
        base_addr = 32'hDEAD_0000; cap_size = 4; mode_continuous = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        repeat (5) step();
        stop = 1'b1;
        step();
        stop = 1'b0;
        wait_idle("ring_stop_timeout", 500);
        chk("ring_cap_done", cap_done, 1);
        chk("ring_err", err, 0);
        chk("ring_wrap_final", wrap_cnt, m_wrap);

        set_ready(1); err_kind = 1; err_idx = 1;
        start_run(32'h4000_0000, 16384, 1'b0);
        wait_idle("slverr_timeout", 500);
        chk("slverr_err", err, 1);
        chk("slverr_code", err_code, 5'b01100);
        chk("slverr_cap_done", cap_done, 0);
        n0 = ncmd;
        repeat (20) step();
        chk("slverr_quiet", ncmd - n0, 0);
        chk("slverr_busy", busy, 0);

        err_kind = 2; err_idx = 1;
        start_run(32'h4800_0000, 16384, 1'b0);
        wait_idle("tagerr_timeout", 500);
        chk("tagerr_err", err, 1);
        chk("tagerr_bit4", err_code[4], 1);
        chk("tagerr_code", err_code, 5'b10000);
        chk("tagerr_cap_done", cap_done, 0);
        err_kind = 0; err_idx = -1;

        for (int i = 0; i < 3; i++) begin
            set_ready(2); auto_sts = 1;
            start_run($urandom, $urandom_range(1, 20000), 1'b0);
            wait_idle("rand_timeout", 1000);
            chk("rand_cap_done", cap_done, 1);
            chk("rand_wrap", wrap_cnt, 1);
            chk("rand_commit", commit_ptr, 0);
            chk("rand_ncmd", ncmd, (m_size + MAXB - 1) / MAXB);
        end

        auto_sts = 0; budget = 0; set_ready(0);
        start_run(32'h5000_0000, 16384, 1'b0);
        step();
        chk("bp_tvalid", m_axis_cmd_tvalid, 1);
        held = m_axis_cmd_tdata;
        repeat (20) begin
            step();
            chk("bp_hold_valid", m_axis_cmd_tvalid, 1);
            chk("bp_hold_data", m_axis_cmd_tdata, held);
        end
        set_ready(1);
        n = 0;
        while (ncmd < 2 && n < 50) begin
            step();
            n++;
        end
        set_ready(0);
        chk("rst_two_out", fly.size(), 2);
        reset = 1'b1;
        step();
        check_reset("midrst");
        fly.delete(); pend.delete(); halted = 1; allowed = 0;
        step();
        reset = 1'b0;
        step();
        step();
        chk("post_rst_busy", busy, 0);
        set_ready(2); auto_sts = 1;
        start_run(32'h6000_0000, 5000, 1'b0);
        wait_idle("post_rst_timeout", 500);
        chk("post_rst_cap_done", cap_done, 1);
        chk("post_rst_ncmd", ncmd, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
